// File: rtl/serializer_link_scheduler.sv
// Round-robin scheduler that shares one 74165-style parallel-in/serial-out register
// between NUM_REQ byte sources, generating its serial clock and one-fall load strobe.
module serializer_link_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int CLK_DIV  = 4,
  parameter int IDLE_GAP = 0,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       ser_clk,
  output logic                       ser_load_n,
  output logic [7:0]                 ser_data_par,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [CNT_W-1:0]           words_sent
);

  localparam int IDW   = $clog2(NUM_REQ);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_ser_clk;
  logic             r_ser_load_n;
  logic [7:0]       r_ser_data_par;
  logic             r_busy;
  logic [IDW-1:0]   r_grant_id;
  logic [IDW-1:0]   r_rr;
  logic [CNT_W-1:0] r_words_sent;
  logic [2:0]       r_shift_cnt;
  logic [GAP_W-1:0] r_gap_cnt;

  logic           w_tick;
  logic           w_rise;
  logic           w_fall;
  logic           w_found;
  logic [IDW-1:0] w_pick;
  logic [IDW:0]   w_sum;
  logic           w_grant;

  assign w_tick = (r_div_cnt == DIV_W'(CLK_DIV - 1));
  assign w_rise = w_tick & ~r_ser_clk;
  assign w_fall = w_tick &  r_ser_clk;

  // Scan from the highest offset down so the nearest valid index at/after r_rr wins.
  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr} + (IDW + 1)'(k);
      if (w_sum >= (IDW + 1)'(NUM_REQ)) w_sum = w_sum - (IDW + 1)'(NUM_REQ);
      if (req_valid[w_sum[IDW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[IDW-1:0];
      end
    end
  end

  assign w_grant   = (r_state == S_IDLE) & w_rise & enable & w_found;
  assign req_ready = w_grant ? (NUM_REQ'(1) << w_pick) : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_div_cnt      <= '0;
      r_ser_clk      <= 1'b1;
      r_ser_load_n   <= 1'b1;
      r_ser_data_par <= '0;
      r_busy         <= 1'b0;
      r_grant_id     <= '0;
      r_rr           <= '0;
      r_words_sent   <= '0;
      r_shift_cnt    <= '0;
      r_gap_cnt      <= '0;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
      if (w_tick) r_ser_clk <= ~r_ser_clk;

      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_ser_data_par <= req_data[{w_pick, 3'b000} +: 8];
            r_ser_load_n   <= 1'b0;
            r_grant_id     <= w_pick;
            r_rr           <= (w_pick == IDW'(NUM_REQ - 1)) ? '0 : w_pick + IDW'(1);
            r_busy         <= 1'b1;
            r_words_sent   <= r_words_sent + CNT_W'(1);
            r_state        <= S_LOAD;
          end
        end
        // Rise to rise spans exactly one fall, where the serializer captures the byte.
        S_LOAD: begin
          if (w_rise) begin
            r_ser_load_n <= 1'b1;
            r_shift_cnt  <= '0;
            r_state      <= S_SHIFT;
          end
        end
        // Seven falls here; the eighth bit leaves on the next load fall or the first gap fall.
        S_SHIFT: begin
          if (w_fall) begin
            if (r_shift_cnt == 3'd6) begin
              if (IDLE_GAP > 0) begin
                r_gap_cnt <= '0;
                r_state   <= S_GAP;
              end else begin
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end
            end else begin
              r_shift_cnt <= r_shift_cnt + 3'd1;
            end
          end
        end
        S_GAP: begin
          if (w_fall) begin
            if (r_gap_cnt == GAP_W'(IDLE_GAP - 1)) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ser_clk      = r_ser_clk;
  assign ser_load_n   = r_ser_load_n;
  assign ser_data_par = r_ser_data_par;
  assign busy         = r_busy;
  assign grant_id     = r_grant_id;
  assign words_sent   = r_words_sent;

endmodule
